// File: rtl/rv_mem_pkg.sv
// rtl/rv_mem_pkg.sv - shared load/store codes, access sizes and FSM states
package rv_mem_pkg;

  localparam logic [2:0] LT_LB  = 3'b000;
  localparam logic [2:0] LT_LH  = 3'b001;
  localparam logic [2:0] LT_LW  = 3'b010;
  localparam logic [2:0] LT_LBU = 3'b100;
  localparam logic [2:0] LT_LHU = 3'b101;

  localparam logic [1:0] ST_SB = 2'b00;
  localparam logic [1:0] ST_SH = 2'b01;
  localparam logic [1:0] ST_SW = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

  // StoreType 11 falls through to word
  function automatic size_t store_size(input logic [1:0] st);
    case (st)
      ST_SB:   return SZ_BYTE;
      ST_SH:   return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

  function automatic size_t load_size(input logic [2:0] lt);
    case (lt)
      LT_LB, LT_LBU: return SZ_BYTE;
      LT_LH, LT_LHU: return SZ_HALF;
      default:       return SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - word-aligned valid/ready memory port
interface mem_access_unit_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_we;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_addr, mem_wdata, mem_be, mem_we, mem_valid,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_be, mem_we, mem_valid,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/load_extend.sv
// rtl/load_extend.sv - lane select and sign/zero extension of a loaded word
module load_extend
  import rv_mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  load_type,
  output logic [31:0] result
);

  logic [31:0] shifted;

  always_comb begin
    shifted = word >> {offset, 3'b000};
    case (load_type)
      LT_LB:   result = {{24{shifted[7]}}, shifted[7:0]};
      LT_LH:   result = {{16{shifted[15]}}, shifted[15:0]};
      LT_LBU:  result = {24'h0, shifted[7:0]};
      LT_LHU:  result = {16'h0, shifted[15:0]};
      default: result = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store stage driving a byte-enabled valid/ready memory port
module mem_access_unit
  import rv_mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [31:0] Adr,
  input  logic [31:0] WriteData,
  input  logic [2:0]  LoadType,
  input  logic [1:0]  StoreType,
  output logic        busy,
  output logic        done,
  output logic [31:0] ReadDataExt,
  output logic        misaligned,
  output logic        timeout,
  mem_access_unit_if.master mem
);

  state_t      state;
  logic [7:0]  wait_cnt;
  logic [1:0]  off_q;
  logic [2:0]  lt_q;
  logic        is_load_q;

  size_t       req_size;
  logic        align_ok;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic [31:0] ext_result;

  always_comb begin
    req_size = req_write ? store_size(StoreType) : load_size(LoadType);
    case (req_size)
      SZ_BYTE: begin
        align_ok  = 1'b1;
        req_be    = 4'b0001 << Adr[1:0];
        req_wdata = {4{WriteData[7:0]}};
      end
      SZ_HALF: begin
        align_ok  = ~Adr[0];
        req_be    = 4'b0011 << {Adr[1], 1'b0};
        req_wdata = {2{WriteData[15:0]}};
      end
      default: begin
        align_ok  = (Adr[1:0] == 2'b00);
        req_be    = 4'b1111;
        req_wdata = WriteData;
      end
    endcase
  end

  // Extends straight off the bus so the result is registered on the handshake edge
  load_extend u_load_extend (
    .word      (mem.mem_rdata),
    .offset    (off_q),
    .load_type (lt_q),
    .result    (ext_result)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= S_IDLE;
      wait_cnt      <= 8'd0;
      off_q         <= 2'b00;
      lt_q          <= 3'b000;
      is_load_q     <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      ReadDataExt   <= 32'h0;
      misaligned    <= 1'b0;
      timeout       <= 1'b0;
      mem.mem_addr  <= 32'h0;
      mem.mem_wdata <= 32'h0;
      mem.mem_be    <= 4'h0;
      mem.mem_we    <= 1'b0;
      mem.mem_valid <= 1'b0;
    end else begin
      done       <= 1'b0;
      misaligned <= 1'b0;
      timeout    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_read || req_write) begin
            if (!align_ok) begin
              misaligned <= 1'b1;
            end else begin
              state         <= S_REQ;
              busy          <= 1'b1;
              wait_cnt      <= 8'd0;
              off_q         <= Adr[1:0];
              lt_q          <= LoadType;
              is_load_q     <= ~req_write;
              mem.mem_addr  <= {Adr[31:2], 2'b00};
              mem.mem_be    <= req_be;
              mem.mem_wdata <= req_write ? req_wdata : 32'h0;
              mem.mem_we    <= req_write;
              mem.mem_valid <= 1'b1;
            end
          end
        end
        S_REQ: begin
          if (mem.mem_ready) begin
            state         <= S_RESP;
            done          <= 1'b1;
            mem.mem_valid <= 1'b0;
            mem.mem_we    <= 1'b0;
            if (is_load_q) ReadDataExt <= ext_result;
          end else if (wait_cnt == 8'(TIMEOUT_CYCLES - 1)) begin
            state         <= S_IDLE;
            busy          <= 1'b0;
            timeout       <= 1'b1;
            wait_cnt      <= 8'd0;
            mem.mem_valid <= 1'b0;
            mem.mem_we    <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_RESP: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
